// File: rtl/priority_encoder_10bit_if.sv
// Ready/valid bundle for priority_encoder_10bit: line-vector input side and encoded-address output.
interface priority_encoder_10bit_if #(
   parameter int unsigned ADDR_W = 10
);
   localparam int unsigned DATA_W = 2 ** ADDR_W;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_addr;
   logic              out_hit;
   logic              out_multi;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_addr, out_hit, out_multi
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_addr, out_hit, out_multi
   );
endinterface

// File: rtl/priority_encoder_10bit.sv
// Sequential lowest-index priority encoder: 1024-bit line vector -> 10-bit address, CHUNK_W bits/cycle.
// Define PRIORITY_ENC_MULTI_DETECT_EN for full-length scans with multiple-hit detection on out_multi.
module priority_encoder_10bit #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned CHUNK_W = 32
) (
   input logic                    clk,
   input logic                    rst,
   priority_encoder_10bit_if.slave bus
);
   localparam int unsigned DATA_W     = 2 ** ADDR_W;
   localparam int unsigned NUM_CHUNKS = DATA_W / CHUNK_W;
   localparam int unsigned OFF_W      = $clog2(CHUNK_W);
   localparam int unsigned K_W        = ADDR_W - OFF_W;

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e                               r_state;
   logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]   r_data;
   logic [K_W-1:0]                       r_k;
   logic                                 r_in_ready;
   logic                                 r_out_valid;
   logic [ADDR_W-1:0]                    r_out_addr;
   logic                                 r_out_hit;

   logic [CHUNK_W-1:0]                   w_chunk;
   logic [OFF_W-1:0]                     w_off;
   logic                                 w_nz;
   logic                                 w_last;

   assign w_chunk = r_data[r_k];
   assign w_nz    = |w_chunk;
   assign w_last  = (r_k == K_W'(NUM_CHUNKS - 1));

   // Descending loop so the lowest set bit is the last (winning) assignment.
   always_comb begin
      w_off = '0;
      for (int i = CHUNK_W - 1; i >= 0; i--) begin
         if (w_chunk[i]) w_off = OFF_W'(i);
      end
   end

`ifdef PRIORITY_ENC_MULTI_DETECT_EN
   logic              r_seen;
   logic              r_multi;
   logic [ADDR_W-1:0] r_first;
   logic              r_out_multi;
   logic              w_many;

   assign w_many        = |(w_chunk & (w_chunk - CHUNK_W'(1)));
   assign bus.out_multi = r_out_multi;
`else
   assign bus.out_multi = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StIdle;
         r_data      <= '0;
         r_k         <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_addr  <= '0;
         r_out_hit   <= 1'b0;
`ifdef PRIORITY_ENC_MULTI_DETECT_EN
         r_seen      <= 1'b0;
         r_multi     <= 1'b0;
         r_first     <= '0;
         r_out_multi <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            StIdle: begin
               if (bus.in_valid && r_in_ready) begin
                  r_data     <= bus.in_data;
                  r_k        <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= StScan;
`ifdef PRIORITY_ENC_MULTI_DETECT_EN
                  r_seen     <= 1'b0;
                  r_multi    <= 1'b0;
                  r_first    <= '0;
`endif
               end
            end
            StScan: begin
`ifdef PRIORITY_ENC_MULTI_DETECT_EN
               // First hit is kept; later chunks only feed the multi flag.
               if (w_nz && !r_seen) begin
                  r_seen  <= 1'b1;
                  r_first <= {r_k, w_off};
               end
               if (w_many || (w_nz && r_seen)) r_multi <= 1'b1;
               if (w_last) begin
                  r_out_valid <= 1'b1;
                  r_out_hit   <= r_seen | w_nz;
                  r_out_addr  <= r_seen ? r_first : (w_nz ? {r_k, w_off} : '0);
                  r_out_multi <= r_multi | w_many | (w_nz & r_seen);
                  r_state     <= StDone;
               end else begin
                  r_k <= r_k + K_W'(1);
               end
`else
               if (w_nz) begin
                  r_out_valid <= 1'b1;
                  r_out_hit   <= 1'b1;
                  r_out_addr  <= {r_k, w_off};
                  r_state     <= StDone;
               end else if (w_last) begin
                  r_out_valid <= 1'b1;
                  r_out_hit   <= 1'b0;
                  r_out_addr  <= '0;
                  r_state     <= StDone;
               end else begin
                  r_k <= r_k + K_W'(1);
               end
`endif
            end
            StDone: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_addr  = r_out_addr;
   assign bus.out_hit   = r_out_hit;
endmodule

// File: tb/tb_priority_encoder_10bit.sv
// Directed scoreboard bench for priority_encoder_10bit; expectations follow the
// PRIORITY_ENC_MULTI_DETECT_EN setting of the build.
module tb_priority_encoder_10bit;
   typedef struct {
      logic [9:0] addr;
      logic       hit;
      logic       multi;
      int         lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t cur;

   always #5 clk = ~clk;

   priority_encoder_10bit_if #(.ADDR_W(10)) bus ();

   priority_encoder_10bit #(
      .ADDR_W (10),
      .CHUNK_W(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [1023:0] v);
      exp_t e;
      int   cnt = 0;
      e.addr = '0;
      e.hit  = 1'b0;
      for (int i = 1023; i >= 0; i--) begin
         if (v[i]) begin
            e.addr = 10'(i);
            e.hit  = 1'b1;
            cnt++;
         end
      end
`ifdef PRIORITY_ENC_MULTI_DETECT_EN
      e.multi = (cnt > 1);
      e.lat   = 32;
`else
      e.multi = 1'b0;
      e.lat   = e.hit ? (int'(e.addr) / 32 + 1) : 32;
`endif
      return e;
   endfunction

   function automatic logic [1023:0] onehot(input int idx);
      logic [1023:0] v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   task automatic accept(input logic [1023:0] v, input bit keep);
      int n = 0;
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("accept_in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      sb.push_back(model(v));
      @(posedge clk);
      @(negedge clk);
      if (!keep) bus.in_valid = 1'b0;
      chk("busy_in_ready", bus.in_ready, 0);
   endtask

   task automatic wait_result(input bit churn);
      int lat = 0;
      bit done = 1'b0;
      while (!done && lat < 40) begin
         if (churn) begin
            chk("churn_in_ready", bus.in_ready, 0);
            bus.in_data = {32{$urandom}};
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus.out_valid) done = 1'b1;
      end
      chk("out_valid_seen", bus.out_valid, 1);
      cur = sb.pop_front();
      chk("out_addr", bus.out_addr, cur.addr);
      chk("out_hit", bus.out_hit, cur.hit);
      chk("out_multi", bus.out_multi, cur.multi);
      chk("latency", lat, cur.lat);
   endtask

   task automatic finish_hs(input int hold);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("hold_valid", bus.out_valid, 1);
         chk("hold_addr", bus.out_addr, cur.addr);
         chk("hold_hit", bus.out_hit, cur.hit);
         chk("hold_multi", bus.out_multi, cur.multi);
         chk("hold_in_ready", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("post_hs_valid", bus.out_valid, 0);
      chk("post_hs_in_ready", bus.in_ready, 1);
   endtask

   task automatic run(input logic [1023:0] v, input int hold);
      bus.out_ready = (hold == 0);
      accept(v, 1'b0);
      wait_result(1'b0);
      finish_hs(hold);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1023:0] v;
      bit            seen;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_addr", bus.out_addr, 0);
      chk("rst_out_hit", bus.out_hit, 0);
      chk("rst_out_multi", bus.out_multi, 0);
      rst = 1'b0;
      @(negedge clk);

      run(onehot(0), 0);
      run(onehot(31), 0);
      run(onehot(32), 0);
      run(onehot(517), 0);
      run(onehot(1023), 0);
      run('0, 0);

      v = onehot(700);
      v[45] = 1'b1;
      run(v, 5);

      // Abort a scan partway through with an asynchronous reset pulse.
      bus.out_ready = 1'b1;
      accept(onehot(1000), 1'b0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("arst_out_addr", bus.out_addr, 0);
      chk("arst_out_hit", bus.out_hit, 0);
      chk("arst_out_valid", bus.out_valid, 0);
      chk("arst_in_ready", bus.in_ready, 1);
      sb.delete();
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      chk("no_valid_after_rst", seen, 0);
      chk("in_ready_after_rst", bus.in_ready, 1);
      run(onehot(3), 0);

      // in_valid held with changing data while busy: only the first vector counts.
      bus.out_ready = 1'b0;
      accept(onehot(600), 1'b1);
      wait_result(1'b1);
      finish_hs(3);

      run(onehot(1), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/priority_encoder_10bit.md
Name: priority_encoder_10bit

Overview:
- Inverse of the SRAM word-line decoder: converts a 1024-bit one-hot or multi-hot line vector (hit/match/valid lines) back into a 10-bit binary address.
- Scans the captured vector sequentially, CHUNK_W bits per cycle; lowest index wins.
- Ready/valid handshake on both sides; used for SRAM match-line readback and free-slot search.

Parameters:
- ADDR_W, 10, address width; vector width DATA_W = 2**ADDR_W = 1024.
- CHUNK_W, 32, bits examined per scan cycle; power of two, divides DATA_W; NUM_CHUNKS = DATA_W/CHUNK_W = 32.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a vector.
- in_data  input  DATA_W  line vector; bit i corresponds to address i.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_addr  output  ADDR_W  lowest set bit index; 0 when out_hit=0.
- out_hit  output  1  at least one bit was set.
- out_multi  output  1  more than one bit set; only with the optional feature, else tied 0.

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_addr=0, out_hit=0, out_multi=0, chunk index 0, capture register 0.
- States:
  - IDLE: in_ready=1. On in_valid & in_ready, capture in_data, set chunk index k=0, go SCAN.
  - SCAN: in_ready=0. Each cycle examines chunk k (bits k*CHUNK_W .. k*CHUNK_W+CHUNK_W-1).
    - Chunk nonzero: out_addr = k*CHUNK_W + lowest set offset; out_hit=1; go DONE.
    - Chunk zero and k = NUM_CHUNKS-1: out_hit=0, out_addr=0; go DONE.
    - Otherwise k increments.
  - DONE: out_valid=1. out_addr, out_hit and out_multi are held stable while out_valid & !out_ready. On out_ready, go IDLE with out_valid=0.
    - There is no same-cycle re-accept. in_ready rises the cycle after the output handshake.
- Latency: hit in chunk k gives out_valid high k+1 cycles after the accept edge. Minimum is 1 (bit in chunk 0); maximum is NUM_CHUNKS (32).
- Throughput: at most one vector per (latency + 1) cycles.
- in_data changes after the accept edge are ignored; the captured copy is used.
- The offset encoder within a chunk is combinational and lowest-index priority. Address arithmetic is unsigned, ADDR_W bits, and cannot overflow.
- Boundaries:
  - All-zero vector: full scan, out_hit=0, out_addr=0.
  - Bit 1023 only: out_addr=1023 after 32 cycles.
  - Bit 0: out_addr=0 with out_hit=1, which distinguishes it from the miss case.
  - in_valid while busy: ignored, in_ready=0.
  - out_ready high before out_valid: no effect.
- Reset asserted mid-SCAN or in DONE: immediately returns to reset values. The partial result is discarded and no out_valid pulse is produced.

Optional Feature:
- Macro PRIORITY_ENC_MULTI_DETECT_EN.
- Defined:
  - SCAN always runs all NUM_CHUNKS chunks. The first hit is latched into out_addr; later chunks do not overwrite it.
  - out_multi=1 if any chunk has 2 or more set bits, or set bits occur in two or more chunks.
  - Latency is fixed at NUM_CHUNKS cycles.
- Undefined:
  - Early termination on the first nonzero chunk, as specified above.
  - out_multi is constant 0 and the multi-detect logic is absent.

Test Plan:
- Reset then accept in_data with only bit 0 set, out_ready=1 -> out_valid after 1 cycle, out_addr=0, out_hit=1; in_ready=1 the cycle after the output handshake.
- Single-bit sweep at addresses 31, 32, 517, 1023 -> out_addr equals the index, out_hit=1; latency 1, 2, 17, 32 cycles without the macro, 32 cycles with it.
- All-zero vector -> out_valid after 32 cycles, out_hit=0, out_addr=0, out_multi=0.
- Bits 700 and 45 set, out_ready held 0 for 5 cycles after out_valid -> out_addr=45 held stable with out_valid high all 5 cycles. With the macro, out_multi=1; without it, out_multi=0 and latency is 2.
- rst pulsed at scan cycle 10 of a vector with only bit 1000 set -> outputs return to 0 asynchronously, no out_valid, in_ready=1 after release. The next vector with only bit 3 set yields out_addr=3.
- in_valid held high with changing in_data during SCAN -> only the first vector is encoded; in_ready stays 0 until the DONE handshake completes.
